// File: rtl/controlpkg.sv
// Shared types for the FP adder control path and its protocol checker.
package controlpkg;

  // Observed adder control FSM state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISSR = 3'd1,
    ALIGN = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } StateType;

  localparam int NRULES = 8;

  // Bit position of each protocol rule in the violation vectors.
  typedef enum logic [2:0] {
    RULE_RST     = 3'd0,
    RULE_GO      = 3'd1,
    RULE_MUX     = 3'd2,
    RULE_SRE     = 3'd3,
    RULE_ONEHOT  = 3'd4,
    RULE_INCDEC  = 3'd5,
    RULE_SHAMT   = 3'd6,
    RULE_TIMEOUT = 3'd7
  } RuleType;

  // Latency watchdog state.
  typedef enum logic [1:0] {
    CK_IDLE    = 2'd0,
    CK_TRACK   = 2'd1,
    CK_TIMEOUT = 2'd2
  } CheckStateType;

  // Index of the lowest set bit; lower rule numbers take priority.
  function automatic logic [2:0] lowest_rule(input logic [NRULES-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NRULES - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ctl_latency_watchdog.sv
// Latency watchdog: counts consecutive non-IDLE cycles and flags one timeout
// per transaction once the count reaches MAXLAT.
module ctl_latency_watchdog
  import controlpkg::*;
#(
  parameter int MAXLAT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  output logic timeout_o,
  output logic busy_o
);

  localparam int CW = $clog2(MAXLAT + 1);

  CheckStateType  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_ni) begin
      state_q <= CK_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and one-shot timeout decode.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_o = 1'b0;
    unique case (state_q)
      CK_IDLE: begin
        if (active_i) begin
          state_d = CK_TRACK;
          cnt_d   = CW'(1);
        end
      end
      CK_TRACK: begin
        if (!active_i) begin
          state_d = CK_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MAXLAT)) begin
          timeout_o = 1'b1;
          state_d   = CK_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CK_TIMEOUT: begin
        if (!active_i) begin
          state_d = CK_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CK_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q != CK_IDLE);

endmodule

// File: rtl/control_checker.sv
// Protocol checker for the FP adder control unit: evaluates eight rules,
// keeps a sticky/first-error/count record and tracks transaction latency.
module control_checker
  import controlpkg::*;
#(
  parameter  int EXPBITS      = 8,
  parameter  int MANTISSABITS = 23,
  localparam int IDXW         = $clog2(MANTISSABITS),
  parameter  int MAXLAT       = 64,
  parameter  int CNTBITS      = 8,
  parameter  int TSBITS       = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Go,
  input  logic                ExpSet,
  input  logic [EXPBITS-1:0]  ExpDiff,
  input  logic [IDXW-1:0]     FFOIndex,
  input  logic [IDXW-1:0]     ShiftAmount,
  input  logic                SelExpMux,
  input  logic                SelSRMuxL,
  input  logic                SelSRMuxG,
  input  logic                ShiftRightEnable,
  input  logic                SREn,
  input  logic                SLEn,
  input  logic                NoShift,
  input  logic                IncrEn,
  input  logic                DecrEn,
  input  StateType            State,
  input  logic [NRULES-1:0]   RuleEnable,
  input  logic                ClearErr,
  output logic [NRULES-1:0]   ErrSticky,
  output logic                ErrValid,
  output logic [2:0]          FirstRule,
  output logic [TSBITS-1:0]   FirstTime,
  output logic [CNTBITS-1:0]  ErrCount,
  output logic                Busy
);

  // Expected left shift is measured at IDXW+1 bits so MANTISSABITS itself fits.
  localparam logic [IDXW:0] MANT_W = (IDXW + 1)'(MANTISSABITS);

  logic [NRULES-1:0]  viol, viol_en;
  logic [IDXW:0]      shamt_exp;
  logic               timeout;
  logic               rst_seen_q, go_seen_q;
  logic [TSBITS-1:0]  ts_q;
  logic [NRULES-1:0]  sticky_q, sticky_d;
  logic               valid_q, valid_d;
  logic [2:0]         first_rule_q, first_rule_d;
  logic [TSBITS-1:0]  first_time_q, first_time_d;
  logic [CNTBITS-1:0] count_q, count_d;

  // ExpSet is observed but no rule currently constrains it.
  logic unused_expset;
  assign unused_expset = ExpSet;

  ctl_latency_watchdog #(
    .MAXLAT (MAXLAT)
  ) u_watchdog (
    .clk_i     (Clock),
    .rst_ni    (Reset),
    .active_i  (State != IDLE),
    .timeout_o (timeout),
    .busy_o    (Busy)
  );

  // Rule evaluation for the current cycle, masked by the enables.
  always_comb begin
    shamt_exp            = MANT_W - {1'b0, FFOIndex};
    viol                 = '0;
    viol[RULE_RST]       = rst_seen_q && (State != IDLE);
    viol[RULE_GO]        = go_seen_q && (State != DISSR);
    viol[RULE_MUX]       = (SelSRMuxG != SelExpMux) || (SelSRMuxL == SelExpMux);
    viol[RULE_SRE]       = (State == DISSR) && (ShiftRightEnable != (ExpDiff != '0));
    viol[RULE_ONEHOT]    = (SREn && SLEn) || (SREn && NoShift) || (SLEn && NoShift);
    viol[RULE_INCDEC]    = (SREn && !IncrEn) || (SLEn && !DecrEn);
    viol[RULE_SHAMT]     = SLEn && ({1'b0, ShiftAmount} != shamt_exp);
    viol[RULE_TIMEOUT]   = timeout;
    viol_en              = viol & RuleEnable;
  end

  // Error record update: clear first, so a same-cycle violation survives it.
  always_comb begin
    sticky_d     = ClearErr ? '0 : sticky_q;
    valid_d      = ClearErr ? 1'b0 : valid_q;
    first_rule_d = ClearErr ? '0 : first_rule_q;
    first_time_d = ClearErr ? '0 : first_time_q;
    count_d      = ClearErr ? '0 : count_q;
    if (|viol_en) begin
      if (!valid_d) begin
        first_rule_d = lowest_rule(viol_en);
        first_time_d = ts_q;
      end
      sticky_d = sticky_d | viol_en;
      valid_d  = 1'b1;
      if (count_d != '1) count_d = count_d + CNTBITS'(1);
    end
  end

  // History, timestamp and record registers; reset also arms the rule-0 history.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rst_seen_q   <= 1'b1;
      go_seen_q    <= 1'b0;
      ts_q         <= '0;
      sticky_q     <= '0;
      valid_q      <= 1'b0;
      first_rule_q <= '0;
      first_time_q <= '0;
      count_q      <= '0;
    end else begin
      rst_seen_q   <= 1'b0;
      go_seen_q    <= (State == IDLE) && Go;
      ts_q         <= ts_q + TSBITS'(1);
      sticky_q     <= sticky_d;
      valid_q      <= valid_d;
      first_rule_q <= first_rule_d;
      first_time_q <= first_time_d;
      count_q      <= count_d;
    end
  end

  assign ErrSticky = sticky_q;
  assign ErrValid  = valid_q;
  assign FirstRule = first_rule_q;
  assign FirstTime = first_time_q;
  assign ErrCount  = count_q;

endmodule

// File: doc/control_checker.md
CONTROL_CHECKER -- requirements
Module: control_checker

Interface
Parameters (name, default, meaning):
REQ-001 EXPBITS, 8, exponent width.
REQ-002 MANTISSABITS, 23, mantissa width; IDXW = $clog2(MANTISSABITS).
REQ-003 MAXLAT, 64, maximum cycles a transaction may spend outside IDLE.
REQ-004 CNTBITS, 8, error-counter width.
REQ-005 TSBITS, 16, timestamp width.

Ports (name, direction, width, meaning):
REQ-006 Clock  in  1  sole clock, rising edge.
REQ-007 Reset  in  1  synchronous, active-low reset.
REQ-008 Go, ExpSet  in  1 each  adder start / exponent-set strobes.
REQ-009 ExpDiff  in  EXPBITS  exponent difference.
REQ-010 FFOIndex, ShiftAmount  in  IDXW each  first-one index / left-shift amount.
REQ-011 SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, SREn, SLEn, NoShift, IncrEn, DecrEn  in  1 each  observed control outputs.
REQ-012 State  in  StateType  observed control FSM state.
REQ-013 RuleEnable  in  NRULES  per-rule enable mask.
REQ-014 ClearErr  in  1  clears error record.
REQ-015 ErrSticky  out  NRULES  per-rule sticky violation flags.
REQ-016 ErrValid  out  1  at least one violation recorded.
REQ-017 FirstRule  out  3  index of first recorded violation.
REQ-018 FirstTime  out  TSBITS  timestamp of first violation.
REQ-019 ErrCount  out  CNTBITS  violating-cycle count, saturating.
REQ-020 Busy  out  1  transaction being tracked.

Function
REQ-021 Rules (index: violation): 0 RST: cycle after Reset low, State != IDLE; 1 GO: cycle after (State==IDLE && Go), State != DISSR; 2 MUX: SelSRMuxG != SelExpMux or SelSRMuxL == SelExpMux; 3 SRE: State==DISSR and ShiftRightEnable != (ExpDiff != 0); 4 ONEHOT: more than one of SREn/SLEn/NoShift high; 5 INCDEC: (SREn && !IncrEn) or (SLEn && !DecrEn); 6 SHAMT: SLEn and ShiftAmount != MANTISSABITS - FFOIndex, compared at IDXW+1 bits, no truncation; 7 TIMEOUT: from watchdog.
REQ-022 Rules 2-6 evaluated combinationally in cycle N; results registered, visible cycle N+1.
REQ-023 Rules 0,1 use one-cycle history registers, evaluated cycle N+1, visible N+2.
REQ-024 Watchdog FSM: CK_IDLE -> CK_TRACK when State != IDLE (counter loads 1); CK_TRACK increments each cycle State != IDLE; State==IDLE -> CK_IDLE; counter == MAXLAT with State != IDLE -> fire rule 7 once, go CK_TIMEOUT; CK_TIMEOUT -> CK_IDLE when State==IDLE.
REQ-025 Busy = watchdog state != CK_IDLE.
REQ-026 Disabled rule sets no sticky bit, no count, no first capture; watchdog runs regardless of mask.
REQ-027 ErrCount +1 per cycle with >=1 enabled violation, saturates at all-ones.
REQ-028 First capture only while ErrValid==0; simultaneous violations -> lowest index wins.
REQ-029 Timestamp free-running from 0, wraps at 2^TSBITS; FirstTime = detection-cycle value.
REQ-030 ClearErr clears ErrSticky, ErrValid, FirstRule, FirstTime, ErrCount; violation in same cycle wins and is captured as new first error.
REQ-031 ClearErr does not affect timestamp or watchdog.

Reset
REQ-032 While Reset low: all outputs 0, timestamp 0, watchdog CK_IDLE, rules 1-7 not evaluated.
REQ-033 Reset low mid-transaction aborts tracking, no timeout reported; rule-0 history register set.

Structure
REQ-034 NRULES (8), rule-index enum RuleType, and CheckStateType (CK_IDLE, CK_TRACK, CK_TIMEOUT) live in controlpkg beside StateType.
REQ-035 Watchdog is sub-module ctl_latency_watchdog; rule logic and record stay in control_checker.

Verification
REQ-036 Reset low 1 cycle, then State=DISSR -> ErrSticky[0]=1, FirstRule=0, ErrValid=1.
REQ-037 SLEn=1, DecrEn=1, FFOIndex=5, ShiftAmount=17 -> ErrSticky[6]=1 next cycle; ShiftAmount=18 -> no error.
REQ-038 Same cycle SelSRMuxG != SelExpMux and SREn=SLEn=1 -> ErrSticky[2]=ErrSticky[4]=1, FirstRule=2, ErrCount=1.
REQ-039 MAXLAT=4, State non-IDLE 10 cycles -> rule 7 fires once, ErrCount=1, Busy high until IDLE.
REQ-040 CNTBITS=2, rule 2 violated 6 consecutive cycles -> ErrCount=3; ClearErr with concurrent violation -> ErrCount=1, ErrValid=1.
REQ-041 RuleEnable[3]=0, State=DISSR, ExpDiff=0, ShiftRightEnable=1 -> ErrSticky=0, ErrCount=0.
